// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed fetch memory with a fixed-latency read pipeline
// and an in-order response FIFO. Define IMEM_ERR_CHECK_EN to flag misaligned/out-of-range fetches.
module imem_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2,
    parameter int RSP_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_inst,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data
);

    localparam int IW   = $clog2(MEM_WORDS);
    localparam int NSTG = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam int PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW   = $clog2(RSP_DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_C    = CW'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST_PTR   = PW'(RSP_DEPTH - 1);
    localparam logic [31:0]   NOP_INST   = 32'h0000_0013;
    localparam logic [32:0]   ADDR_LIMIT = 33'(MEM_WORDS) << 2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } entry_t;

    logic [31:0]   mem [MEM_WORDS];
    logic          accept;
    logic          pop;
    logic          push;
    entry_t        req_entry;
    entry_t        push_entry;
    entry_t        head;

    logic [NSTG-1:0] pv_q;
    entry_t          pe_q [NSTG];

    entry_t        fifo_q [RSP_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] out_q;

    logic          unused_wr_bits;
    assign unused_wr_bits = ^{wr_addr[31:IW+2], wr_addr[1:0]};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign req_ready = reset && !flush && (out_q < DEPTH_C);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (cnt_q != '0);
    assign pop       = rsp_valid && rsp_ready;

    // NOTE: every field gets a default before any conditional override, so no latch can form.
    always_comb begin
        req_entry      = '0;
        req_entry.inst = mem[req_addr[IW+1:2]];
        req_entry.addr = req_addr;
`ifdef IMEM_ERR_CHECK_EN
        req_entry.err  = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= ADDR_LIMIT);
        if (req_entry.err) begin
            req_entry.inst = NOP_INST;
        end
`else
        req_entry.err  = 1'b0;
`endif
    end

    // NOTE: memory and data-path registers carry no reset; only valid bits, pointers and
    // counters do, which is all that decides whether stale data can ever be observed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[IW+1:2]] <= wr_data;
        end
    end

    // Pipeline stages in front of the FIFO; the FIFO register itself is the final stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pv_q <= '0;
        end else if (flush) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= accept;
            for (int i = 1; i < NSTG; i++) begin
                pv_q[i] <= pv_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pe_q[0] <= req_entry;
        for (int i = 1; i < NSTG; i++) begin
            pe_q[i] <= pe_q[i-1];
        end
    end

    assign push       = (LATENCY == 1) ? accept    : pv_q[NSTG-1];
    assign push_entry = (LATENCY == 1) ? req_entry : pe_q[NSTG-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
            out_q <= out_q + CW'(accept) - CW'(pop);
        end
    end

    // Outstanding never exceeds RSP_DEPTH, so a push always finds a free slot.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head     = fifo_q[rd_ptr_q];
    assign rsp_inst = rsp_valid ? head.inst : '0;
    assign rsp_addr = rsp_valid ? head.addr : '0;
    assign rsp_err  = rsp_valid ? head.err  : 1'b0;

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder (default parameters; honours IMEM_ERR_CHECK_EN).
module tb_imem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_inst;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    vec_t vecs [6];

    imem_responder #(.MEM_WORDS(1024), .LATENCY(LAT), .RSP_DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_inst  (rsp_inst),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic expect_rsp(input string name, input logic [31:0] addr,
                              input logic [31:0] inst, input logic err);
        check({name, " valid"}, 32'(rsp_valid), 32'd1);
        check({name, " addr"},  rsp_addr, addr);
        check({name, " inst"},  rsp_inst, inst);
        check({name, " err"},   32'(rsp_err), 32'(err));
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        cyc();
        wr_en   = 1'b0;
    endtask

    // Single request with rsp_ready=1: response must appear exactly LAT cycles after acceptance.
    task automatic fetch(input string name, input logic [31:0] addr,
                         input logic [31:0] inst, input logic err);
        req_valid = 1'b1;
        req_addr  = addr;
        rsp_ready = 1'b1;
        settle();
        check({name, " req_ready"}, 32'(req_ready), 32'd1);
        cyc();
        req_valid = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            settle();
            check({name, " early rsp"}, 32'(rsp_valid), 32'd0);
            cyc();
        end
        settle();
        expect_rsp(name, addr, inst, err);
        cyc();
        settle();
        check({name, " after pop"}, 32'(rsp_valid), 32'd0);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"w4",    32'h0000_0010, 32'h0050_0093, 1'b0};
        vecs[1] = '{"w0",    32'h0000_0000, 32'h1111_1111, 1'b0};
        vecs[2] = '{"wlast", 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0};
`ifdef IMEM_ERR_CHECK_EN
        vecs[3] = '{"oor",   32'h0000_1000, 32'h0000_0013, 1'b1};
        vecs[4] = '{"mis",   32'h0000_0006, 32'h0000_0013, 1'b1};
        vecs[5] = '{"oor2",  32'h0000_1010, 32'h0000_0013, 1'b1};
`else
        vecs[3] = '{"wrap",  32'h0000_1000, 32'h1111_1111, 1'b0};
        vecs[4] = '{"mis",   32'h0000_0006, 32'h2222_2222, 1'b0};
        vecs[5] = '{"wrap2", 32'h0000_1010, 32'h0050_0093, 1'b0};
`endif

        reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;

        cyc();
        cyc();
        settle();
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_inst",  rsp_inst, 32'd0);
        check("rst rsp_addr",  rsp_addr, 32'd0);
        check("rst rsp_err",   32'(rsp_err), 32'd0);
        cyc();
        reset = 1'b1;
        settle();
        check("ready after reset", 32'(req_ready), 32'd1);
        cyc();

        load(32'h0000_0010, 32'h0050_0093);
        load(32'h0000_0000, 32'h1111_1111);
        load(32'h0000_0004, 32'h2222_2222);
        load(32'h0000_0008, 32'h3333_3333);
        load(32'h0000_0020, 32'h4444_4444);
        load(32'h0000_0FFC, 32'hCAFE_F00D);

        for (int i = 0; i < 6; i++) begin
            fetch(vecs[i].name, vecs[i].addr, vecs[i].inst, vecs[i].err);
        end

        // Backpressure: two accepts fill the outstanding budget; 0x8 waits for the first pop.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        settle();
        check("bp ready c0", 32'(req_ready), 32'd1);
        cyc();
        req_addr = 32'h4;
        settle();
        check("bp ready c1", 32'(req_ready), 32'd1);
        cyc();
        req_addr = 32'h8;
        settle();
        check("bp full c2", 32'(req_ready), 32'd0);
        expect_rsp("bp head c2", 32'h0, 32'h1111_1111, 1'b0);
        cyc();
        settle();
        check("bp full c3", 32'(req_ready), 32'd0);
        expect_rsp("bp hold c3", 32'h0, 32'h1111_1111, 1'b0);
        cyc();
        rsp_ready = 1'b1;
        settle();
        check("bp pop cycle ready", 32'(req_ready), 32'd0);
        cyc();
        rsp_ready = 1'b0;
        settle();
        check("bp slot freed", 32'(req_ready), 32'd1);
        expect_rsp("bp head 0x4", 32'h4, 32'h2222_2222, 1'b0);
        cyc();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        settle();
        expect_rsp("bp rsp 0x4", 32'h4, 32'h2222_2222, 1'b0);
        cyc();
        settle();
        expect_rsp("bp rsp 0x8", 32'h8, 32'h3333_3333, 1'b0);
        cyc();
        settle();
        check("bp drained", 32'(rsp_valid), 32'd0);
        cyc();

        // Flush with one response queued and one in the pipeline; request during flush is refused.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        cyc();
        req_addr = 32'h4;
        cyc();
        req_addr = 32'h20;
        flush    = 1'b1;
        settle();
        check("flush ready", 32'(req_ready), 32'd0);
        cyc();
        flush     = 1'b0;
        rsp_ready = 1'b1;
        settle();
        check("flush rsp gone", 32'(rsp_valid), 32'd0);
        check("flush ready back", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 1'b0;
        settle();
        check("flush no stale", 32'(rsp_valid), 32'd0);
        cyc();
        settle();
        expect_rsp("post flush 0x20", 32'h20, 32'h4444_4444, 1'b0);
        cyc();
        settle();
        check("post flush drained", 32'(rsp_valid), 32'd0);
        cyc();

        // Same-cycle write and fetch of word 4: old data first, new data afterwards.
        req_valid = 1'b1;
        req_addr  = 32'h10;
        wr_en     = 1'b1;
        wr_addr   = 32'h10;
        wr_data   = 32'hDEAD_BEEF;
        settle();
        check("rbw ready", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 1'b0;
        wr_en     = 1'b0;
        settle();
        check("rbw early", 32'(rsp_valid), 32'd0);
        cyc();
        settle();
        expect_rsp("rbw old", 32'h10, 32'h0050_0093, 1'b0);
        cyc();
        fetch("rbw new", 32'h10, 32'hDEAD_BEEF, 1'b0);

        // Reset mid-operation with one queued and one in-flight response.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        cyc();
        req_addr = 32'h4;
        cyc();
        req_valid = 1'b0;
        check("pre-reset queued", 32'(rsp_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("async rsp_valid", 32'(rsp_valid), 32'd0);
        check("async req_ready", 32'(req_ready), 32'd0);
        check("async rsp_inst",  rsp_inst, 32'd0);
        check("async rsp_addr",  rsp_addr, 32'd0);
        cyc();
        cyc();
        reset = 1'b1;
        settle();
        check("release ready", 32'(req_ready), 32'd1);
        check("release rsp", 32'(rsp_valid), 32'd0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            settle();
            check("no stale after reset", 32'(rsp_valid), 32'd0);
            cyc();
        end
        fetch("mem kept", 32'h8, 32'h3333_3333, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, 1024, instruction memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, 2, cycles from request acceptance to response availability (legal 1..4).
REQ-003 SHALL have parameter RSP_DEPTH, 2, maximum outstanding requests (in-flight plus queued; legal 1..4).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req_valid input 1, req_ready output 1, req_addr input 32: fetch request, byte address from the IF stage.
REQ-007 SHALL have port flush  input  1  discard all in-flight and queued responses (branch/jump redirect).
REQ-008 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_inst output 32, rsp_addr output 32, rsp_err output 1: response channel.
REQ-009 SHALL have ports wr_en input 1, wr_addr input 32, wr_data input 32: word-write loader port.

Function
REQ-010 SHALL accept a request in the cycle where req_valid and req_ready are both 1; no other cycle accepts.
REQ-011 SHALL drive req_ready = 1 only when reset is high, flush is 0, and outstanding count < RSP_DEPTH (a pop in the same cycle does not free a slot until the next cycle).
REQ-012 SHALL read memory word req_addr[log2(MEM_WORDS)+1:2] in the acceptance cycle; a same-cycle write to that word returns the old data (read-before-write).
REQ-013 SHALL carry each accepted request through exactly LATENCY pipeline stages, then push {inst, addr, err} into an internal response FIFO.
REQ-014 SHALL assert rsp_valid whenever the FIFO is non-empty, presenting the oldest entry; responses are returned strictly in acceptance order.
REQ-015 SHALL pop the head entry when rsp_valid and rsp_ready are both 1; simultaneous push and pop SHALL both occur and leave occupancy unchanged.
REQ-016 SHALL hold rsp_inst, rsp_addr and rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-017 SHALL, on flush=1, invalidate all pipeline stages and empty the FIFO at the next edge; rsp_valid SHALL be 0 the cycle after flush; a request presented during flush is not accepted.
REQ-018 SHALL count outstanding = in-flight + queued, increment on accept, decrement on pop, cleared on flush; it never exceeds RSP_DEPTH and never underflows.
REQ-019 SHALL perform wr_en writes at the rising edge to word wr_addr[log2(MEM_WORDS)+1:2], independent of the request channel and flush.

Reset
REQ-020 SHALL, while reset=0, force req_ready=0, rsp_valid=0, rsp_inst=0, rsp_addr=0, rsp_err=0, outstanding=0, all pipeline valid bits 0.
REQ-021 SHALL not reset memory contents; reset asserted mid-operation discards all outstanding requests without producing responses.
REQ-022 SHALL raise req_ready in the first cycle after reset deasserts.

Configuration
REQ-023 SHALL, with macro IMEM_ERR_CHECK_EN defined, flag a request as error when req_addr[1:0] != 0 or req_addr >= MEM_WORDS*4; the response then carries rsp_err=1 and rsp_inst=32'h00000013 (NOP) with normal latency and ordering.
REQ-024 SHALL, without IMEM_ERR_CHECK_EN, tie rsp_err to 0, ignore req_addr[1:0], and wrap the word index modulo MEM_WORDS.

Verification
REQ-025 SHALL cover: load word 4 (addr 0x10) = 0x00500093, request 0x10 with rsp_ready=1 -> rsp_valid exactly LATENCY cycles later, rsp_inst=0x00500093, rsp_addr=0x10, rsp_err=0.
REQ-026 SHALL cover: back-to-back requests 0x0,0x4,0x8 with rsp_ready=0 -> req_ready drops after RSP_DEPTH=2 accepts; 0x8 accepted only after first pop; responses in order 0x0,0x4,0x8.
REQ-027 SHALL cover: two requests in flight, flush asserted one cycle -> no response for either; request 0x20 after flush returns normally.
REQ-028 SHALL cover (IMEM_ERR_CHECK_EN): request 0x6 -> rsp_err=1, rsp_inst=0x00000013; request 0x1000 with MEM_WORDS=1024 -> rsp_err=1; without macro, 0x1000 returns word 0.
REQ-029 SHALL cover: wr_en to 0x10 with data 0xDEADBEEF in same cycle as request 0x10 -> response returns old data; next request 0x10 returns 0xDEADBEEF.
REQ-030 SHALL cover: reset pulled low with one queued and one in-flight response -> rsp_valid=0 immediately, no stale response after reset release, req_ready=1 the cycle after release.
